// File: rtl/fc_pkg.sv
// fc_pkg: shared state type, default widths and Q-format
// output arithmetic for the fully-connected layer blocks.
package fc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FINAL,
    S_OUTPUT
  } fc_state_e;

  localparam int FC_IN_FEATURES = 16;
  localparam int FC_NUM_NEURONS = 10;
  localparam int FC_WEIGHT_W    = 16;
  localparam int FC_DATA_W      = 16;
  localparam int FC_FRAC_BITS   = 8;
  localparam int FC_ACC_W       = 40;
  localparam int FC_T_W         = FC_ACC_W + 2;

  // Bias add, round half up, saturate, optional ReLU.
  function automatic logic [FC_DATA_W-1:0] sat_round(
    input logic signed [FC_ACC_W-1:0]  acc,
    input logic signed [FC_DATA_W-1:0] bias,
    input logic                        relu
  );
    logic signed [FC_T_W-1:0]   t;
    logic [FC_T_W-FC_DATA_W:0]  hi;
    logic [FC_DATA_W-1:0]       y;
    t = FC_T_W'(acc)
      + (FC_T_W'(bias) <<< FC_FRAC_BITS)
      + (FC_T_W'(1) <<< (FC_FRAC_BITS - 1));
    t  = t >>> FC_FRAC_BITS;
    hi = t[FC_T_W-1:FC_DATA_W-1];
    if (!hi[FC_T_W-FC_DATA_W] && (|hi))
      y = {1'b0, {(FC_DATA_W-1){1'b1}}};
    else if (hi[FC_T_W-FC_DATA_W] && !(&hi))
      y = {1'b1, {(FC_DATA_W-1){1'b0}}};
    else
      y = t[FC_DATA_W-1:0];
    if (relu && y[FC_DATA_W-1])
      y = '0;
    return y;
  endfunction

endpackage

// File: rtl/fc_layer_mac_seq_lane.sv
// fc_mac_lane: one neuron's multiply-accumulate register
// plus its combinational bias/round/saturate output stage.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = FC_DATA_W,
  parameter int WEIGHT_WIDTH = FC_WEIGHT_W,
  parameter int FRAC_BITS    = FC_FRAC_BITS,
  parameter int ACC_WIDTH    = FC_ACC_W,
  parameter bit RELU_EN      = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clr,
  input  logic                           i_en,
  input  logic signed [DATA_WIDTH-1:0]   i_x,
  input  logic signed [WEIGHT_WIDTH-1:0] i_w,
  input  logic signed [DATA_WIDTH-1:0]   i_bias,
  output logic [DATA_WIDTH-1:0]          o_y
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int TW = ACC_WIDTH + 2;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [PW-1:0]        w_prod;
  logic signed [TW-1:0]        w_t;
  logic [TW-DATA_WIDTH:0]      w_hi;

  assign w_prod = i_x * i_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_acc <= '0;
    else if (i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= r_acc + ACC_WIDTH'(w_prod);
  end

  // Two guard bits keep the bias and rounding add from wrapping.
  assign w_t = (TW'(r_acc)
             + (TW'(i_bias) <<< FRAC_BITS)
             + (TW'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
  assign w_hi = w_t[TW-1:DATA_WIDTH-1];

  always_comb begin
    o_y = w_t[DATA_WIDTH-1:0];
    if (!w_hi[TW-DATA_WIDTH] && (|w_hi))
      o_y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_hi[TW-DATA_WIDTH] && !(&w_hi))
      o_y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (RELU_EN && o_y[DATA_WIDTH-1])
      o_y = '0;
  end

endmodule

// File: rtl/fc_layer_mac_seq.sv
// fc_layer_mac_seq: walks the packed-weight ROM one feature
// per handshake, accumulates all neurons, emits one vector.
module fc_layer_mac_seq
  import fc_pkg::*;
#(
  parameter int IN_FEATURES  = FC_IN_FEATURES,
  parameter int NUM_NEURONS  = FC_NUM_NEURONS,
  parameter int WEIGHT_WIDTH = FC_WEIGHT_W,
  parameter int DATA_WIDTH   = FC_DATA_W,
  parameter int FRAC_BITS    = FC_FRAC_BITS,
  parameter int ACC_WIDTH    = FC_ACC_W,
  parameter int ADDR_WIDTH   = $clog2(IN_FEATURES),
  parameter bit RELU_EN      = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0]   bias_vec,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0]   out_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IN_FEATURES - 1);

  fc_state_e                         r_state;
  fc_state_e                         w_next;
  logic [ADDR_WIDTH-1:0]             r_idx;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] r_out;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] w_lane_y;
  logic                              w_hs;
  logic                              w_clr;

  assign w_hs  = in_valid && (r_state == S_ACCUM);
  assign w_clr = start && (r_state == S_IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_ACCUM;
      S_ACCUM:  if (w_hs && (r_idx == LAST)) w_next = S_FINAL;
      S_FINAL:  w_next = S_OUTPUT;
      S_OUTPUT: if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr)
        r_idx <= '0;
      else if (w_hs)
        r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
      if (r_state == S_FINAL)
        r_out <= w_lane_y;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_OUTPUT);
  assign rom_addr  = r_idx;
  assign out_data  = r_out;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
    fc_mac_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .FRAC_BITS    (FRAC_BITS),
      .ACC_WIDTH    (ACC_WIDTH),
      .RELU_EN      (RELU_EN)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_hs),
      .i_x    (in_data),
      .i_w    (rom_data[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .i_bias (bias_vec[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_y    (w_lane_y[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_fc_layer_mac_seq.sv
// tb_fc_layer_mac_seq: drives directed and random inferences into
// plain and ReLU instances, checks against an arithmetic model.
module tb_fc_layer_mac_seq;

  localparam int NF = 16;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int VW = NN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [VW-1:0] bias_vec, rom_data0, rom_data1, out0, out1;
  logic [3:0]    rom_addr0, rom_addr1;
  logic          busy0, busy1, in_ready0, in_ready1;
  logic          out_valid0, out_valid1;

  logic [DW-1:0] X [NF];
  logic [DW-1:0] W [NF][NN];
  logic [DW-1:0] B [NN];
  logic [VW-1:0] exp0, exp1, lit;
  int            tests = 0;
  int            fails = 0;
  bit            nogap = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    bias_vec  = '0;
    rom_data0 = '0;
    rom_data1 = '0;
    for (int i = 0; i < NN; i++) begin
      bias_vec[i*DW +: DW]  = B[i];
      rom_data0[i*DW +: DW] = W[rom_addr0][i];
      rom_data1[i*DW +: DW] = W[rom_addr1][i];
    end
  end

  fc_layer_mac_seq u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .bias_vec(bias_vec),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out0)
  );

  fc_layer_mac_seq #(.RELU_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .bias_vec(bias_vec),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out1)
  );

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] model_lane(input longint acc,
                                               input longint b,
                                               input bit relu);
    longint t;
    t = (acc + b * 256 + 128) >>> 8;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    if (relu && t < 0) t = 0;
    return DW'(t);
  endfunction

  task automatic compute_exp();
    longint acc;
    for (int i = 0; i < NN; i++) begin
      acc = 0;
      for (int k = 0; k < NF; k++)
        acc += longint'($signed(X[k])) * longint'($signed(W[k][i]));
      exp0[i*DW +: DW] = model_lane(acc, longint'($signed(B[i])), 1'b0);
      exp1[i*DW +: DW] = model_lane(acc, longint'($signed(B[i])), 1'b1);
    end
  endtask

  task automatic setup(input logic [DW-1:0] wv, input logic [DW-1:0] xv,
                       input logic [DW-1:0] bv);
    for (int k = 0; k < NF; k++) begin
      X[k] = xv;
      for (int i = 0; i < NN; i++) W[k][i] = wv;
    end
    for (int i = 0; i < NN; i++) B[i] = bv;
  endtask

  task automatic do_run(input int gap, input int hold, input int nfeed,
                        input bit start_hs);
    int k;
    int guard;
    bit hs;
    @(posedge clk); #1;
    compute_exp();
    nogap = (gap == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    guard = 0;
    while (k < nfeed && guard < 4000) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = X[k];
      end
      hs = in_valid && in_ready0;
      if (hs) chk("rom_addr", VW'(rom_addr0), VW'(k));
      @(posedge clk); #1;
      guard++;
      if (hs) k++;
    end
    chk("feed_count", VW'(k), VW'(nfeed));
    if (nfeed < NF) return;
    in_valid = 1'($urandom_range(0, 1));
    in_data  = DW'($urandom);
    guard = 0;
    while (!out_valid0 && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ov_wait", VW'(out_valid0), VW'(1));
    repeat (hold) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start     = start_hs;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  // Cycle-by-cycle output checker.
  int n = 0;
  int n_start = 0;
  int cnt = 0;
  bit pend = 1'b0;
  bit prev_ov = 1'b0;
  bit prev_rdy = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend = 1'b0;
      prev_ov = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      n++;
      if (pend) cnt++;
      if (start && !busy0) n_start = n;
      if (out_valid0) begin
        chk("out_plain", out0, exp0);
        chk("out_relu", out1, exp1);
        chk("out_ctl", VW'({busy0, in_ready0, out_valid1}), VW'(3'b101));
        if (!prev_ov) begin
          chk("lat_last", VW'(cnt), VW'(2));
          pend = 1'b0;
          if (nogap) chk("lat_start", VW'(n - n_start), VW'(18));
        end
      end
      if (prev_ov && !prev_rdy) chk("ov_hold", VW'(out_valid0), VW'(1));
      if (prev_ov && prev_rdy) begin
        chk("hs_idle", VW'({out_valid0, busy0}), VW'(0));
        chk("hs_keep", out0, exp0);
      end
      if (in_valid && in_ready0 && rom_addr0 == 4'd15) begin
        pend = 1'b1;
        cnt = 0;
      end
      prev_ov  = out_valid0;
      prev_rdy = out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    setup(16'h0000, 16'h0000, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst0_ctl", VW'({busy0, in_ready0, out_valid0, rom_addr0}), '0);
    chk("rst0_data", out0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    setup(16'h0100, 16'h0100, 16'h0000);
    do_run(0, 0, NF, 1'b0);
    chk("model_pin_t1", exp0, {NN{16'h1000}});
    chk("t1_ident", out0, {NN{16'h1000}});

    setup(16'h0000, 16'h0000, 16'h0080);
    for (int k = 0; k < NF; k++)
      for (int i = 0; i < NN; i++) W[k][i] = DW'(i * 256);
    X[0] = 16'h0100;
    do_run(0, 0, NF, 1'b0);
    for (int i = 0; i < NN; i++) lit[i*DW +: DW] = DW'(i * 256 + 128);
    chk("t2_lanes", out0, lit);
    chk("t2_lane9", VW'(out0[9*DW +: DW]), VW'(16'h0980));

    setup(16'h7FFF, 16'h7FFF, 16'h0000);
    do_run(0, 0, NF, 1'b0);
    chk("t3_satpos", out0, {NN{16'h7FFF}});
    chk("t3_satpos_relu", out1, {NN{16'h7FFF}});
    setup(16'h8000, 16'h7FFF, 16'h0000);
    do_run(0, 0, NF, 1'b0);
    chk("t3_satneg", out0, {NN{16'h8000}});
    chk("t3_satneg_relu", out1, '0);

    setup(16'h0100, 16'h0100, 16'h0000);
    do_run(40, 5, NF, 1'b0);
    chk("t4_gaps_bp", out0, {NN{16'h1000}});
    do_run(0, 3, NF, 1'b1);
    chk("t4_start_at_hs", out0, {NN{16'h1000}});

    setup(16'h0200, 16'h0300, 16'h0100);
    do_run(0, 0, 7, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl", VW'({busy0, in_ready0, out_valid0, rom_addr0}), '0);
    chk("t5_rst_data", out0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    setup(16'h0100, 16'h0100, 16'h0000);
    do_run(0, 0, NF, 1'b0);
    chk("t5_rerun", out0, {NN{16'h1000}});

    setup(16'h0100, 16'h0000, 16'hFF80);
    X[0] = 16'h0180;
    do_run(0, 0, NF, 1'b0);
    chk("model_pin_t6a", exp0, {NN{16'h0100}});
    chk("t6_round_a", out0, {NN{16'h0100}});
    setup(16'h0001, 16'h0000, 16'h0000);
    X[0] = 16'h00C0;
    do_run(0, 0, NF, 1'b0);
    chk("t6_round_b", out0, {NN{16'h0001}});

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NF; k++) begin
        X[k] = DW'(int'($urandom_range(0, 4095)) - 2048);
        for (int i = 0; i < NN; i++)
          W[k][i] = DW'(int'($urandom_range(0, 1023)) - 512);
      end
      for (int i = 0; i < NN; i++) B[i] = DW'($urandom);
      do_run(int'($urandom_range(0, 60)), int'($urandom_range(0, 6)),
             NF, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_layer_mac_seq.md
Name: fc_layer_mac_seq

Overview:
- Sequencer/datapath that reads a packed-weight ROM for one fully-connected layer.
- Drives the ROM address with the current input-feature index and accepts one input feature per handshake. It multiplies that feature by all NUM_NEURONS weights in parallel and accumulates.
- After the last feature it adds the biases, then rounds, saturates and optionally applies ReLU.
- Emits one packed output vector per inference to the next layer over a valid/ready handshake.

Parameters:
- IN_FEATURES, 16, number of input features (ROM depth in packed words)
- NUM_NEURONS, 10, neurons per layer (lanes per ROM word)
- WEIGHT_WIDTH, 16, signed weight width
- DATA_WIDTH, 16, signed activation width, in and out
- FRAC_BITS, 8, fractional bits of the Q-format shared by weights, activations and biases
- ACC_WIDTH, 40, signed accumulator width per neuron
- ADDR_WIDTH, $clog2(IN_FEATURES), ROM address width
- RELU_EN, 0, 1 = clamp negative outputs to 0

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one inference; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  input feature valid
- in_ready  out  1  block accepts feature
- in_data  in  DATA_WIDTH  signed input feature, delivered in index order 0..IN_FEATURES-1
- rom_addr  out  ADDR_WIDTH  feature index presented to ROM
- rom_data  in  NUM_NEURONS*WEIGHT_WIDTH  packed weights; lane i = bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = neuron i
- bias_vec  in  NUM_NEURONS*DATA_WIDTH  packed signed biases, same lane order; static during a run
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_NEURONS*DATA_WIDTH  packed results, lane i = neuron i

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, idx=0, accumulators=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0, rom_addr=0.
- ROM read is combinational. rom_addr is the registered idx, so rom_data matches in_data in the same cycle.
- IDLE:
  - in_ready=0.
  - start=1 -> clear all accumulators, idx=0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc[i] += sext(in_data*w[i]), where each product is a full 2*DATA_WIDTH-bit signed product; then idx++.
  - No handshake -> hold everything. Gaps in in_valid are legal.
  - Handshake with idx==IN_FEATURES-1 -> idx=0, go to FINAL.
- FINAL (one cycle):
  - t[i] = acc[i] + (sext(bias[i]) << FRAC_BITS) + (1 << (FRAC_BITS-1)), then arithmetic shift right by FRAC_BITS (round half up).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. If RELU_EN, negatives become 0.
  - Register the result into out_data, set out_valid=1, go to OUTPUT.
- OUTPUT:
  - out_data and out_valid are held stable while out_ready=0.
  - out_valid&&out_ready -> out_valid=0, go to IDLE. out_data keeps its last value.
- Latency: out_valid rises on the 2nd rising edge after the edge that accepts the last feature. Minimum start-to-out_valid is IN_FEATURES+2 cycles.
- start outside IDLE is ignored. start and the out handshake in the same cycle: the out handshake completes, and start is not sampled (still OUTPUT). start is honoured next cycle.
- Reset asserted mid-ACCUM or mid-OUTPUT aborts the run immediately to the reset values. Any partial result is discarded.
- in_ready is never high outside ACCUM. Extra input features offered after the last one are not consumed.

Decomposition:
- Package fc_pkg:
  - state enum (IDLE, ACCUM, FINAL, OUTPUT).
  - Width constants and the default Q-format FRAC_BITS.
  - Function sat_round(acc, bias) implementing the FINAL arithmetic, reused by other fc layers.
- Sub-module fc_mac_lane: one neuron's accumulator, with clr, en, x, w, bias and the saturated/rounded result. Instantiated NUM_NEURONS times in a generate loop.
- Top holds the FSM, idx counter and handshakes.

Test Plan:
1. Identity sum: all weights 0x0100 (1.0), 16 features of 0x0100, bias 0 -> every lane 0x1000 (16.0).
   - out_valid at cycle start+18 with continuous in_valid.
2. Lane order: ROM weights for neuron i = i*0x0100; x0=0x0100, x1..x15=0; bias[i]=0x0080.
   - Lane i = i*0x0100+0x0080, e.g. lane 9 = 0x0980.
   - Confirms rom_addr stepping 0..15 and lane mapping.
3. Saturation: weights 0x7FFF, inputs 0x7FFF -> all lanes 0x7FFF.
   - Weights 0x8000, inputs 0x7FFF -> all lanes 0x8000.
   - With RELU_EN=1 the same negative case -> 0x0000.
4. Backpressure:
   - Random in_valid gaps give the same result as test 1.
   - out_ready low for 5 cycles -> out_data/out_valid stable, in_ready=0, start ignored.
   - Handshake completes on the cycle out_ready rises.
5. Reset mid-ACCUM: assert rst_n=0 after 7 features.
   - All outputs go to reset values asynchronously.
   - A new full run then gives the test 1 result, with no residue from the aborted run.
6. Rounding: single product 0x0180*0x0100 (1.5) plus bias 0xFF80 (-0.5) -> 0x0100.
   - Accumulator value 0x00C0 (0.75 after shift) -> 0x0001 (round half up at bit FRAC_BITS-1).
